// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared constants for the instruction fetch stage.
//   PC_SIZE_DEFAULT : default width of word-addressed PC values
//   INSTR_W         : instruction word width
//   NOP_INSTR       : instruction value used on reset and on branch squash
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int          PC_SIZE_DEFAULT = 32;
    localparam int          INSTR_W         = 32;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage control, instruction-memory and decode-side signals.
//   master : pipeline control / instruction memory side (drives stalls, branch
//            info and RD; observes PCF, PCPlus1D, InstrD)
//   slave  : the fetch stage side (the opposite directions)
// Parameter PC_SIZE : width of PC-valued signals.
// -----------------------------------------------------------------------------
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int PC_SIZE = PC_SIZE_DEFAULT
);

    logic                 StallF;
    logic                 StallD;
    logic                 PCSrcD;
    logic [PC_SIZE-1:0]   PCBranchD;
    logic [INSTR_W-1:0]   RD;
    logic [PC_SIZE-1:0]   PCPlus1D;
    logic [PC_SIZE-1:0]   PCF;
    logic [INSTR_W-1:0]   InstrD;

    modport master (
        output StallF, StallD, PCSrcD, PCBranchD, RD,
        input  PCPlus1D, PCF, InstrD
    );

    modport slave (
        input  StallF, StallD, PCSrcD, PCBranchD, RD,
        output PCPlus1D, PCF, InstrD
    );

endinterface : fetch_stage_if

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// Generic pipeline register with synchronous active-high reset, load enable
// and synchronous clear. Used for the IF/ID register and the PC register.
//   clk    : clock
//   reset  : synchronous active-high reset, forces the register to zero
//   en_i   : 1 = register may update, 0 = hold (hold beats clear)
//   clr_i  : 1 = load zero instead of d_i (only when en_i = 1)
//   d_i    : data in
//   q_o    : registered data out
// -----------------------------------------------------------------------------
module if_id_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state select: hold has priority over clear, clear over load.
    always_comb begin
        data_d = data_q;
        if (!en_i) begin
            data_d = data_q;
        end else if (clr_i) begin
            data_d = {WIDTH{1'b0}};
        end else begin
            data_d = d_i;
        end
    end

    // State register with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= {WIDTH{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: PC register, PC+1 incrementer, next-PC select and
// the IF/ID pipeline register feeding decode. Instruction memory is external
// and combinational: RD is the word at PCF in the same cycle.
//   clk       : clock, all state on rising edge
//   StallF    : 1 = hold the PC register
//   StallD    : 1 = hold the IF/ID register
//   PCSrcD    : 1 = next PC is PCBranchD
//   PCBranchD : branch target word address
//   RD        : instruction word read at PCF
//   PCPlus1D  : registered PCF+1 for decode
//   PCF       : current fetch address (PC register output)
//   InstrD    : registered instruction for decode
//   reset     : synchronous active-high reset
// Configuration macro: FETCH_BRANCH_FLUSH_EN -- when defined, a taken branch
// (PCSrcD=1, StallD=0) squashes the IF/ID contents to zero (NOP). When not
// defined, the wrong-path instruction proceeds as a delay slot.
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int PC_SIZE = PC_SIZE_DEFAULT
) (
    input  logic                clk,
    input  logic                StallF,
    input  logic                StallD,
    input  logic                PCSrcD,
    input  logic [PC_SIZE-1:0]  PCBranchD,
    input  logic [INSTR_W-1:0]  RD,
    output logic [PC_SIZE-1:0]  PCPlus1D,
    output logic [PC_SIZE-1:0]  PCF,
    output logic [INSTR_W-1:0]  InstrD,
    input  logic                reset
);

    localparam int IFID_W = INSTR_W + PC_SIZE;

    logic [PC_SIZE-1:0] pc_q;
    logic [PC_SIZE-1:0] pc_plus1_s;
    logic [PC_SIZE-1:0] pc_d;
    logic [IFID_W-1:0]  ifid_d;
    logic [IFID_W-1:0]  ifid_q;
    logic               flush_s;

    // Incrementer truncates to PC_SIZE, so the all-ones address wraps to 0.
    assign pc_plus1_s = pc_q + PC_SIZE'(1);

    // Next-PC select between branch target and sequential address.
    always_comb begin
        pc_d = pc_plus1_s;
        if (PCSrcD) begin
            pc_d = PCBranchD;
        end else begin
            pc_d = pc_plus1_s;
        end
    end

`ifdef FETCH_BRANCH_FLUSH_EN
    // A taken branch squashes the instruction fetched behind it.
    assign flush_s = PCSrcD;
`else
    assign flush_s = 1'b0;
`endif

    // PC register; a stall drops any branch target presented this cycle.
    if_id_reg #(
        .WIDTH (PC_SIZE)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (~StallF),
        .clr_i (1'b0),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    assign ifid_d = {RD, pc_plus1_s};

    // IF/ID register; StallD holds, which takes priority over the flush.
    if_id_reg #(
        .WIDTH (IFID_W)
    ) u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (~StallD),
        .clr_i (flush_s),
        .d_i   (ifid_d),
        .q_o   (ifid_q)
    );

    assign PCF      = pc_q;
    assign InstrD   = ifid_q[IFID_W-1:PC_SIZE];
    assign PCPlus1D = ifid_q[PC_SIZE-1:0];

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed stimulus with hand-computed expectations pushed into a scoreboard
// queue; an independent monitor pops and compares after each active edge.
// PC_SIZE = 3 so wrap-around is reachable quickly.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int PCW = 3;
`ifdef FETCH_BRANCH_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    typedef struct {
        int           cyc;
        string        name;
        logic [PCW-1:0] pcf;
        logic [31:0]  instr;
        logic [PCW-1:0] p1;
    } exp_t;

    logic clk;
    logic reset;
    fetch_stage_if #(.PC_SIZE(PCW)) bus ();

    exp_t exp_q[$];
    int   cyc_cnt  = 0;
    int   checks   = 0;
    int   failures = 0;

    fetch_stage #(.PC_SIZE(PCW)) dut (
        .clk       (clk),
        .StallF    (bus.StallF),
        .StallD    (bus.StallD),
        .PCSrcD    (bus.PCSrcD),
        .PCBranchD (bus.PCBranchD),
        .RD        (bus.RD),
        .PCPlus1D  (bus.PCPlus1D),
        .PCF       (bus.PCF),
        .InstrD    (bus.InstrD),
        .reset     (reset)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to time scoreboard entries.
    always @(posedge clk) cyc_cnt = cyc_cnt + 1;

    // Monitor: compare all entries due by this cycle on the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            exp_t e;
            e = exp_q.pop_front();
            checks = checks + 1;
            if (bus.PCF !== e.pcf) begin
                failures = failures + 1;
                $display("FAIL %s PCF got=%0d exp=%0d", e.name, bus.PCF, e.pcf);
            end
            checks = checks + 1;
            if (bus.InstrD !== e.instr) begin
                failures = failures + 1;
                $display("FAIL %s InstrD got=%h exp=%h", e.name, bus.InstrD, e.instr);
            end
            checks = checks + 1;
            if (bus.PCPlus1D !== e.p1) begin
                failures = failures + 1;
                $display("FAIL %s PCPlus1D got=%0d exp=%0d", e.name, bus.PCPlus1D, e.p1);
            end
        end
    end

    // Apply inputs for the next edge and push the state expected after it.
    task automatic drv(input logic rst, input logic sf, input logic sd,
                       input logic src, input logic [PCW-1:0] br,
                       input logic [31:0] rd, input logic [PCW-1:0] e_pc,
                       input logic [31:0] e_in, input logic [PCW-1:0] e_p1,
                       input string nm);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        bus.StallF    = sf;
        bus.StallD    = sd;
        bus.PCSrcD    = src;
        bus.PCBranchD = br;
        bus.RD        = rd;
        e.cyc   = cyc_cnt + 1;
        e.name  = nm;
        e.pcf   = e_pc;
        e.instr = e_in;
        e.p1    = e_p1;
        exp_q.push_back(e);
    endtask

    // Directed stimulus sequence.
    initial begin
        int wait_cnt;
        reset = 1'b1;
        bus.StallF = 1'b0; bus.StallD = 1'b0; bus.PCSrcD = 1'b0;
        bus.PCBranchD = 3'd4; bus.RD = 32'd3;

        //    rst   sf    sd    src   br    rd      pcf   instr  p1
        drv(1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 32'd3, 3'd0, 32'd0, 3'd0, "reset");
        drv(1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 32'd3, 3'd1, 32'd3, 3'd1, "seq_fetch");
        drv(1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 32'd5, 3'd1, 32'd3, 3'd1, "stall_1");
        drv(1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 32'd5, 3'd1, 32'd3, 3'd1, "stall_2");
        drv(1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 32'd3, 3'd4,
            FLUSH ? 32'd0 : 32'd3, FLUSH ? 3'd0 : 3'd2, "branch");
        drv(1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 32'd6, 3'd5, 32'd6, 3'd5, "seq_5");
        drv(1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 32'd7, 3'd6, 32'd7, 3'd6, "seq_6");
        drv(1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 32'd1, 3'd7, 32'd1, 3'd7, "seq_7");
        drv(1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 32'd2, 3'd0, 32'd2, 3'd0, "wrap");
        drv(1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 32'd4, 3'd1, 32'd2, 3'd0, "split_sd_1");
        drv(1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 32'd4, 3'd2, 32'd2, 3'd0, "split_sd_2");
        drv(1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 32'd5, 3'd2, 32'd5, 3'd3, "split_sf");
        drv(1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 32'd5, 3'd2,
            FLUSH ? 32'd0 : 32'd5, FLUSH ? 3'd0 : 3'd3, "branch_sf");
        drv(1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 32'd7, 3'd6,
            FLUSH ? 32'd0 : 32'd5, FLUSH ? 3'd0 : 3'd3, "branch_sd");
        drv(1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 32'd7, 3'd0, 32'd0, 3'd0, "reset_override");
        drv(1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 32'd3, 3'd1, 32'd3, 3'd1, "post_reset");

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt = wait_cnt + 1;
        end
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32: width in bits of every PC-valued port and register (word-addressed PC).
REQ-002 SHALL use positional port order clk, StallF, StallD, PCSrcD, PCBranchD, RD, PCPlus1D, PCF, InstrD, reset; reset is appended last so the other positions are fixed.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 StallF  input  1  1 = hold the PC register.
REQ-007 StallD  input  1  1 = hold the IF/ID register.
REQ-008 PCSrcD  input  1  1 = next PC is PCBranchD (branch resolved taken in decode).
REQ-009 PCBranchD  input  PC_SIZE  branch target word address.
REQ-010 RD  input  32  instruction word read from instruction memory at PCF (combinational memory, external).
REQ-011 PCPlus1D  output  PC_SIZE  registered PCF+1 for the decode stage.
REQ-012 PCF  output  PC_SIZE  current fetch address, the PC register output directly.
REQ-013 InstrD  output  32  registered instruction for the decode stage.

Function
REQ-014 PCPlus1F SHALL equal PCF + 1, truncated to PC_SIZE bits (all-ones wraps to 0); no carry out.
REQ-015 PCnext SHALL be PCBranchD when PCSrcD=1, else PCPlus1F.
REQ-016 The PC register SHALL load PCnext on each rising edge with reset=0 and StallF=0, and hold when StallF=1.
REQ-017 The IF/ID register SHALL load InstrD<=RD and PCPlus1D<=PCPlus1F on each rising edge with reset=0 and StallD=0, and hold both when StallD=1.
REQ-018 Fetch-to-decode latency SHALL be exactly one cycle; RD is sampled in the same cycle PCF presents its address.
REQ-019 StallF and StallD SHALL act independently; any combination is legal.
REQ-020 When PCSrcD=1 and StallF=1, the PC SHALL hold; the branch target is lost unless PCSrcD is still asserted after the stall.
REQ-021 The block SHALL contain no combinational path from inputs to PCPlus1D or InstrD.
REQ-022 PCF SHALL depend only on the PC register.

Reset
REQ-023 When reset=1 at a rising edge, PCF SHALL become 0, and InstrD and PCPlus1D SHALL become 0.
REQ-024 Reset SHALL override StallF, StallD, PCSrcD and any flush.
REQ-025 Reset asserted mid-stall or mid-branch SHALL abandon that operation.
REQ-026 After reset deasserts, the first fetch SHALL be from address 0.

Configuration
REQ-027 With macro FETCH_BRANCH_FLUSH_EN defined, a rising edge with PCSrcD=1 and StallD=0 SHALL clear InstrD and PCPlus1D to 0, squashing the wrong-path instruction (0 is a NOP).
REQ-028 With FETCH_BRANCH_FLUSH_EN undefined, no flush logic SHALL exist, and the instruction after a branch SHALL proceed to decode as a delay slot.
REQ-029 Under FETCH_BRANCH_FLUSH_EN, StallD=1 SHALL take priority over the flush.

Structure
REQ-030 A shared package SHALL hold the default PC width constant, the 32-bit instruction width, and the NOP/reset instruction constant (32'h0000_0000).
REQ-031 The IF/ID register SHALL be one sub-module, if_id_reg: parameterised width, synchronous reset, enable, and optional clear; the PC register MAY also instantiate it.

Verification (PC_SIZE=3, RD=3, PCBranchD=4)
REQ-032 Reset: reset=1 for one edge -> PCF=0, InstrD=0, PCPlus1D=0.
REQ-033 Sequential fetch: no stalls, PCSrcD=0, one edge after reset -> PCF=1, InstrD=3, PCPlus1D=1.
REQ-034 Stall: StallF=StallD=1 for two edges from PCF=1 -> PCF, InstrD and PCPlus1D unchanged (1, 3, 1).
REQ-035 Branch: stalls released, PCSrcD=1, one edge -> PCF=4; PCPlus1D=2 without FETCH_BRANCH_FLUSH_EN, PCPlus1D=0 and InstrD=0 with it.
REQ-036 Wrap-around: PCF=7, PCSrcD=0 -> next PCF=0 and PCPlus1D=0.
REQ-037 Split stall: StallF=0, StallD=1 -> PCF advances while InstrD and PCPlus1D hold.
